// File: rtl/swd_transfer_engine_if.sv
// swd_transfer_engine_if
// Bundles the three signal groups of the SWD transfer engine:
//   xfer_* / retry_limit : transfer request from the host (valid/ready handshake)
//   rsp_*                : one-cycle result strobe with held status/ack/rdata
//   seq_*                : command/response channel to the bit-level SWD sequencer
// Modports:
//   slave  - the transfer engine itself
//   master - the host plus sequencer side that drives and observes the engine
interface swd_transfer_engine_if;
  logic        xfer_valid;
  logic        xfer_ready;
  logic        xfer_apndp;
  logic        xfer_rnw;
  logic [1:0]  xfer_a;
  logic [31:0] xfer_wdata;
  logic [15:0] retry_limit;

  logic        rsp_valid;
  logic [2:0]  rsp_status;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;

  logic        seq_tx_valid;
  logic [15:0] seq_tx_cmd;
  logic [63:0] seq_tx_data;
  logic        seq_rx_valid;
  logic [63:0] seq_rx_data;

  modport slave (
    input  xfer_valid, xfer_apndp, xfer_rnw, xfer_a, xfer_wdata, retry_limit,
    input  seq_rx_valid, seq_rx_data,
    output xfer_ready, rsp_valid, rsp_status, rsp_ack, rsp_rdata,
    output seq_tx_valid, seq_tx_cmd, seq_tx_data
  );

  modport master (
    output xfer_valid, xfer_apndp, xfer_rnw, xfer_a, xfer_wdata, retry_limit,
    output seq_rx_valid, seq_rx_data,
    input  xfer_ready, rsp_valid, rsp_status, rsp_ack, rsp_rdata,
    input  seq_tx_valid, seq_tx_cmd, seq_tx_data
  );
endinterface

// File: rtl/swd_transfer_engine.sv
// swd_transfer_engine
// Runs one SWD transfer (request, ACK, data phase with WAIT retries) by issuing
// a series of bit-sequence commands to an external sequencer, one at a time,
// with an enforced idle gap between commands.
// Ports:
//   clk    - controller clock, rising edge
//   resetn - asynchronous active-low reset
//   bus    - swd_transfer_engine_if.slave (request, response and sequencer groups)
module swd_transfer_engine #(
  parameter logic [3:0] SEQ_CMD_SWD_SEQ = 4'h1,
  parameter int         GAP_CYCLES      = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  swd_transfer_engine_if.slave  bus
);
  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_WAIT     = 3'd1;
  localparam logic [2:0] ST_FAULT    = 3'd2;
  localparam logic [2:0] ST_PROTOCOL = 3'd3;
  localparam logic [2:0] ST_PARITY   = 3'd4;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ACK, S_RD, S_TRNW, S_WR, S_TRNE, S_RSP
  } state_t;

  state_t        state_reg;
  logic          xfer_ready_reg;
  logic          apndp_reg;
  logic          rnw_reg;
  logic [1:0]    a_reg;
  logic [31:0]   wdata_reg;
  logic [15:0]   retry_cnt_reg;
  logic [2:0]    ack_reg;
  logic [GW-1:0] gap_cnt_reg;
  logic          rx_prev_reg;
  logic          seq_tx_valid_reg;
  logic [15:0]   seq_tx_cmd_reg;
  logic [63:0]   seq_tx_data_reg;
  logic          rsp_valid_reg;
  logic [2:0]    rsp_status_reg;
  logic [2:0]    rsp_ack_reg;
  logic [31:0]   rsp_rdata_reg;

  // Input commands return bit k (first received = 0) at seq_rx_data[N-1-k].
  // rd_bits: 34-bit read phase, bits 0..31 data, bit 32 parity (turnaround dropped).
  // ack_in : 4-bit ACK phase, ack = {bit3, bit2, bit1} (turnaround bit0 dropped).
  logic [32:0] rd_bits;
  logic [2:0]  ack_in;
  logic        rd_par_ok;
  logic        rx_rise;
  logic        unused_rx_hi;

  generate
    for (genvar gi = 0; gi < 33; gi++) begin : g_rd_bits
      assign rd_bits[gi] = bus.seq_rx_data[33-gi];
    end
    for (genvar gi = 0; gi < 3; gi++) begin : g_ack_bits
      assign ack_in[gi] = bus.seq_rx_data[2-gi];
    end
  endgenerate

  assign rd_par_ok    = ~(^rd_bits);
  assign rx_rise      = bus.seq_rx_valid & ~rx_prev_reg;
  assign unused_rx_hi = ^bus.seq_rx_data[63:34];

  // Command word and shift data for the phase the FSM is currently in.
  logic        cmd_dir;
  logic [6:0]  cmd_len;
  logic [63:0] cmd_data;
  logic        req_par;

  assign req_par = apndp_reg ^ rnw_reg ^ a_reg[0] ^ a_reg[1];

  always_comb begin
    cmd_dir  = 1'b0;
    cmd_len  = 7'd0;
    cmd_data = '0;
    case (state_reg)
      S_REQ: begin
        cmd_len       = 7'd8;
        // park, stop, parity, A3, A2, RnW, APnDP, start (bit 0 shifted first)
        cmd_data[7:0] = {1'b1, 1'b0, req_par, a_reg[1], a_reg[0], rnw_reg, apndp_reg, 1'b1};
      end
      S_ACK: begin
        cmd_dir = 1'b1;
        cmd_len = 7'd4;
      end
      S_RD: begin
        cmd_dir = 1'b1;
        cmd_len = 7'd34;
      end
      S_TRNW, S_TRNE: begin
        cmd_dir = 1'b1;
        cmd_len = 7'd1;
      end
      S_WR: begin
        cmd_len        = 7'd33;
        cmd_data[32:0] = {^wdata_reg, wdata_reg};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg        <= S_IDLE;
      xfer_ready_reg   <= 1'b1;
      apndp_reg        <= 1'b0;
      rnw_reg          <= 1'b0;
      a_reg            <= '0;
      wdata_reg        <= '0;
      retry_cnt_reg    <= '0;
      ack_reg          <= '0;
      gap_cnt_reg      <= '0;
      rx_prev_reg      <= 1'b0;
      seq_tx_valid_reg <= 1'b0;
      seq_tx_cmd_reg   <= '0;
      seq_tx_data_reg  <= '0;
      rsp_valid_reg    <= 1'b0;
      rsp_status_reg   <= '0;
      rsp_ack_reg      <= '0;
      rsp_rdata_reg    <= '0;
    end else begin
      rx_prev_reg   <= bus.seq_rx_valid;
      rsp_valid_reg <= 1'b0;
      // Gap counter counts down while no command is presented and sticks at 0.
      if (!seq_tx_valid_reg && gap_cnt_reg != '0)
        gap_cnt_reg <= gap_cnt_reg - GW'(1);

      case (state_reg)
        S_IDLE: begin
          if (bus.xfer_valid && xfer_ready_reg) begin
            apndp_reg      <= bus.xfer_apndp;
            rnw_reg        <= bus.xfer_rnw;
            a_reg          <= bus.xfer_a;
            wdata_reg      <= bus.xfer_wdata;
            retry_cnt_reg  <= bus.retry_limit;
            xfer_ready_reg <= 1'b0;
            state_reg      <= S_REQ;
          end
        end
        S_RSP: begin
          xfer_ready_reg <= 1'b1;
          state_reg      <= S_IDLE;
        end
        default: begin
          if (!seq_tx_valid_reg) begin
            if (gap_cnt_reg == '0) begin
              seq_tx_valid_reg <= 1'b1;
              seq_tx_cmd_reg   <= {SEQ_CMD_SWD_SEQ, 4'h0, cmd_dir, cmd_len};
              seq_tx_data_reg  <= cmd_data;
            end
          end else if (rx_rise) begin
            // Command completed: retire it, start the gap, advance one phase.
            seq_tx_valid_reg <= 1'b0;
            gap_cnt_reg      <= GAP_LOAD;
            rsp_rdata_reg    <= rsp_rdata_reg;
            case (state_reg)
              S_REQ: state_reg <= S_ACK;
              S_ACK: begin
                ack_reg <= ack_in;
                if (ack_in == ACK_OK) begin
                  state_reg <= rnw_reg ? S_RD : S_TRNW;
                end else if (ack_in == ACK_WAIT || ack_in == ACK_FAULT) begin
                  state_reg <= S_TRNE;
                end else begin
                  state_reg      <= S_RSP;
                  rsp_valid_reg  <= 1'b1;
                  rsp_status_reg <= ST_PROTOCOL;
                  rsp_ack_reg    <= ack_in;
                  rsp_rdata_reg  <= '0;
                end
              end
              S_RD: begin
                state_reg      <= S_RSP;
                rsp_valid_reg  <= 1'b1;
                rsp_status_reg <= rd_par_ok ? ST_OK : ST_PARITY;
                rsp_ack_reg    <= ack_reg;
                rsp_rdata_reg  <= rd_bits[31:0];
              end
              S_TRNW: state_reg <= S_WR;
              S_WR: begin
                state_reg      <= S_RSP;
                rsp_valid_reg  <= 1'b1;
                rsp_status_reg <= ST_OK;
                rsp_ack_reg    <= ack_reg;
                rsp_rdata_reg  <= '0;
              end
              S_TRNE: begin
                if (ack_reg == ACK_WAIT && retry_cnt_reg != '0) begin
                  retry_cnt_reg <= retry_cnt_reg - 16'd1;
                  state_reg     <= S_REQ;
                end else begin
                  state_reg      <= S_RSP;
                  rsp_valid_reg  <= 1'b1;
                  rsp_status_reg <= (ack_reg == ACK_WAIT) ? ST_WAIT : ST_FAULT;
                  rsp_ack_reg    <= ack_reg;
                  rsp_rdata_reg  <= '0;
                end
              end
              default: state_reg <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.xfer_ready   = xfer_ready_reg;
  assign bus.seq_tx_valid = seq_tx_valid_reg;
  assign bus.seq_tx_cmd   = seq_tx_cmd_reg;
  assign bus.seq_tx_data  = seq_tx_data_reg;
  assign bus.rsp_valid    = rsp_valid_reg;
  assign bus.rsp_status   = rsp_status_reg;
  assign bus.rsp_ack      = rsp_ack_reg;
  assign bus.rsp_rdata    = rsp_rdata_reg;
endmodule

// File: tb/tb_swd_transfer_engine.sv
// tb_swd_transfer_engine
// Scoreboard bench: each planned transfer pushes the expected sequencer commands
// and the expected response; a sequencer model answers commands and a monitor
// checks responses, gaps and output stability independently of the stimulus.
module tb_swd_transfer_engine;
  localparam int         GAP = 8;
  localparam logic [3:0] SEQ = 4'h1;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  swd_transfer_engine_if bus();

  swd_transfer_engine #(.SEQ_CMD_SWD_SEQ(SEQ), .GAP_CYCLES(GAP)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    logic [63:0] data;
    bit          chk_data;
    logic [63:0] rx;
    bit          hang;
  } cmd_t;

  typedef struct {
    logic [2:0]  status;
    logic [2:0]  ack;
    logic [31:0] rdata;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int checks = 0;
  int errors = 0;
  int n_rsp  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // ---------------- reference model helpers ----------------
  function automatic logic [15:0] mk_cmd(input bit inp, input int n);
    return {SEQ, 4'h0, inp, 7'(n)};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Received bit k must appear at rx[n-1-k]; unused positions carry junk.
  function automatic logic [63:0] pack_in(input logic [63:0] bits, input int n);
    logic [63:0] r;
    r = rand64();
    for (int k = 0; k < n; k++) r[n-1-k] = bits[k];
    return r;
  endfunction

  function automatic logic [63:0] ack_bits(input logic [2:0] ack);
    return {60'd0, ack, 1'($urandom_range(0, 1))};
  endfunction

  task automatic push_out(input int n, input logic [63:0] d);
    cmd_t e;
    e.cmd = mk_cmd(1'b0, n); e.data = d; e.chk_data = 1'b1; e.rx = rand64(); e.hang = 1'b0;
    cmd_q.push_back(e);
  endtask

  task automatic push_in(input int n, input logic [63:0] bits, input bit hang);
    cmd_t e;
    e.cmd = mk_cmd(1'b1, n); e.data = '0; e.chk_data = 1'b0; e.rx = pack_in(bits, n); e.hang = hang;
    cmd_q.push_back(e);
  endtask

  // One transfer: n_wait WAIT replies, then the final ACK 'fin'.
  task automatic plan(input bit apndp, input bit rnw, input logic [1:0] a, input logic [31:0] wdata,
                      input int n_wait, input logic [2:0] fin, input logic [31:0] rdata,
                      input bit bad_par, input bit hang);
    logic [63:0] req;
    logic [63:0] bits;
    bit par;
    rsp_t r;
    par = apndp ^ rnw ^ a[0] ^ a[1];
    req = 64'd1 + 64'(apndp) * 2 + 64'(rnw) * 4 + 64'(a) * 8 + 64'(par) * 32 + 64'd128;
    for (int i = 0; i < n_wait; i++) begin
      push_out(8, req);
      push_in(4, ack_bits(3'b010), 1'b0);
      push_in(1, rand64(), 1'b0);
    end
    push_out(8, req);
    push_in(4, ack_bits(fin), 1'b0);
    r.ack = fin;
    r.rdata = '0;
    if (fin == 3'b001 && rnw) begin
      bits = 64'(rdata) | (64'((^rdata) ^ bad_par) << 32) | (64'($urandom_range(0, 1)) << 33);
      push_in(34, bits, hang);
      r.status = bad_par ? 3'd4 : 3'd0;
      r.rdata  = rdata;
    end else if (fin == 3'b001) begin
      push_in(1, rand64(), 1'b0);
      push_out(33, 64'(wdata) | (64'(^wdata) << 32));
      r.status = 3'd0;
    end else if (fin == 3'b010) begin
      push_in(1, rand64(), 1'b0);
      r.status = 3'd1;
    end else if (fin == 3'b100) begin
      push_in(1, rand64(), 1'b0);
      r.status = 3'd2;
    end else begin
      r.status = 3'd3;
    end
    if (!hang) rsp_q.push_back(r);
  endtask

  // ---------------- host-side stimulus tasks ----------------
  task automatic issue(input bit apndp, input bit rnw, input logic [1:0] a,
                       input logic [31:0] wdata, input int rl);
    int t;
    t = 0;
    while (!bus.xfer_ready && t < 2000) begin @(posedge clk); #1; t++; end
    if (!bus.xfer_ready) begin
      chk("ready_timeout", 64'(bus.xfer_ready), 64'd1);
      finish_sim();
    end
    bus.xfer_valid = 1'b1; bus.xfer_apndp = apndp; bus.xfer_rnw = rnw;
    bus.xfer_a = a; bus.xfer_wdata = wdata; bus.retry_limit = 16'(rl);
    @(posedge clk); #1;
    // Keep a junk request up while busy; it must be ignored.
    bus.xfer_apndp = ~apndp; bus.xfer_rnw = ~rnw; bus.xfer_wdata = $urandom;
    bus.retry_limit = 16'($urandom);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.xfer_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((rsp_q.size() != 0 || cmd_q.size() != 0) && t < 5000) begin @(posedge clk); t++; end
    if (t >= 5000) begin
      chk("done_timeout_rsp_q", 64'(rsp_q.size()), 64'd0);
      finish_sim();
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_xfer_ready"}, 64'(bus.xfer_ready), 64'd1);
    chk({tag, "_tx_valid"}, 64'(bus.seq_tx_valid), 64'd0);
    chk({tag, "_tx_cmd"}, 64'(bus.seq_tx_cmd), 64'd0);
    chk({tag, "_tx_data"}, bus.seq_tx_data, 64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_status"}, 64'(bus.rsp_status), 64'd0);
    chk({tag, "_rsp_ack"}, 64'(bus.rsp_ack), 64'd0);
    chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
  endtask

  // ---------------- sequencer model ----------------
  initial begin : seq_model
    cmd_t e;
    int d;
    int h;
    bus.seq_rx_valid = 1'b0;
    bus.seq_rx_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.seq_tx_valid && resetn) begin
        if (cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd: actual cmd %h required none", bus.seq_tx_cmd);
          e.cmd = bus.seq_tx_cmd; e.data = '0; e.chk_data = 1'b0; e.rx = rand64(); e.hang = 1'b0;
        end else begin
          e = cmd_q.pop_front();
        end
        chk("tx_cmd", 64'(bus.seq_tx_cmd), 64'(e.cmd));
        if (e.chk_data) chk("tx_data", bus.seq_tx_data, e.data);
        if (e.hang) begin
          for (int t = 0; t < 500 && bus.seq_tx_valid; t++) begin @(posedge clk); #1; end
        end else begin
          d = $urandom_range(0, 3);
          repeat (d) begin @(posedge clk); #1; end
          bus.seq_rx_data  = e.rx;
          bus.seq_rx_valid = 1'b1;
          h = $urandom_range(1, 5);
          repeat (h) begin @(posedge clk); #1; end
          bus.seq_rx_valid = 1'b0;
          bus.seq_rx_data  = rand64();
          // Stray response pulse while nothing is outstanding: must be ignored.
          if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
            bus.seq_rx_valid = 1'b1;
            @(posedge clk); #1;
            bus.seq_rx_valid = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- gap and command-stability monitor ----------------
  initial begin : gap_mon
    int low_run;
    bit armed;
    bit prev_tx;
    logic [15:0] held_cmd;
    logic [63:0] held_data;
    low_run = 0; armed = 1'b0; prev_tx = 1'b0; held_cmd = '0; held_data = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        low_run = 0; armed = 1'b0; prev_tx = 1'b0;
      end else begin
        if (bus.seq_tx_valid && !prev_tx) begin
          if (armed) begin
            checks++;
            if (low_run < GAP) begin
              errors++;
              $display("FAIL gap: actual %0d low cycles required >= %0d", low_run, GAP);
            end
          end
          held_cmd = bus.seq_tx_cmd; held_data = bus.seq_tx_data;
          armed = 1'b1; low_run = 0;
        end else if (bus.seq_tx_valid) begin
          chk("tx_cmd_stable", 64'(bus.seq_tx_cmd), 64'(held_cmd));
          chk("tx_data_stable", bus.seq_tx_data, held_data);
        end else begin
          low_run++;
        end
        prev_tx = bus.seq_tx_valid;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin : rsp_mon
    rsp_t exp;
    rsp_t last;
    last = '{3'd0, 3'd0, 32'd0};
    forever begin
      @(negedge clk);
      if (!resetn) begin
        last = '{3'd0, 3'd0, 32'd0};
      end else if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: actual rsp_valid 1 status %0d required no response", bus.rsp_status);
        end else begin
          exp = rsp_q.pop_front();
          n_rsp++;
          $display("xfer %0d: status %0d ack %b rdata %h (expected %0d %b %h)",
                   n_rsp, bus.rsp_status, bus.rsp_ack, bus.rsp_rdata, exp.status, exp.ack, exp.rdata);
          chk("rsp_status", 64'(bus.rsp_status), 64'(exp.status));
          chk("rsp_ack", 64'(bus.rsp_ack), 64'(exp.ack));
          chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp.rdata));
          last = exp;
        end
      end else begin
        chk("rsp_hold", 64'({bus.rsp_status, bus.rsp_ack, bus.rsp_rdata}),
            64'({last.status, last.ack, last.rdata}));
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin : stim
    bit ap;
    bit rw;
    bit bp;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [2:0]  fin;
    int rl;
    int nw;
    int sc;
    int t;

    bus.xfer_valid = 1'b0; bus.xfer_apndp = 1'b0; bus.xfer_rnw = 1'b0;
    bus.xfer_a = '0; bus.xfer_wdata = '0; bus.retry_limit = '0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    // DP read addr 0, OK, IDCODE-like data
    plan(1'b0, 1'b1, 2'b00, 32'h0, 0, 3'b001, 32'h2BA01477, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 2'b00, 32'h0, 0);
    wait_done();
    // AP write A=01, wdata 3
    plan(1'b1, 1'b0, 2'b01, 32'h00000003, 0, 3'b001, 32'h0, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 2'b01, 32'h00000003, 0);
    wait_done();
    // retry_limit 2, three WAITs
    plan(1'b0, 1'b1, 2'b10, 32'h0, 2, 3'b010, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 2'b10, 32'h0, 2);
    wait_done();
    // read with flipped parity
    plan(1'b1, 1'b1, 2'b11, 32'h0, 0, 3'b001, 32'hDEADBEEF, 1'b1, 1'b0);
    issue(1'b1, 1'b1, 2'b11, 32'h0, 0);
    wait_done();
    // PROTOCOL ack 111, no TRNE
    plan(1'b0, 1'b0, 2'b01, 32'h12345678, 0, 3'b111, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 1'b0, 2'b01, 32'h12345678, 3);
    wait_done();
    // FAULT
    plan(1'b1, 1'b0, 2'b00, 32'h55AA55AA, 0, 3'b100, 32'h0, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 2'b00, 32'h55AA55AA, 1);
    wait_done();

    for (int i = 0; i < 40; i++) begin
      ap = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
      a = 2'($urandom_range(0, 3)); wd = $urandom; rd = $urandom;
      rl = $urandom_range(0, 3); nw = $urandom_range(0, rl);
      sc = $urandom_range(0, 5); fin = 3'b001; bp = 1'b0;
      case (sc)
        2: begin fin = 3'b010; nw = rl; end
        3: fin = 3'b100;
        4: begin
          fin = 3'($urandom_range(0, 7));
          while (fin == 3'b001 || fin == 3'b010 || fin == 3'b100) fin = 3'($urandom_range(0, 7));
        end
        5: begin rw = 1'b1; bp = 1'b1; end
        default: ;
      endcase
      plan(ap, rw, a, wd, nw, fin, rd, bp, 1'b0);
      issue(ap, rw, a, wd, rl);
      wait_done();
    end

    // Reset while the read-data command is outstanding.
    plan(1'b0, 1'b1, 2'b01, 32'h0, 0, 3'b001, 32'hCAFEF00D, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 2'b01, 32'h0, 0);
    t = 0;
    while (!(bus.seq_tx_valid && bus.seq_tx_cmd[6:0] == 7'd34) && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    chk("rd_phase_reached", 64'(bus.seq_tx_cmd[6:0]), 64'd34);
    repeat (2) begin @(posedge clk); #1; end
    resetn = 1'b0;
    #2;
    chk_reset_vals("midrd_reset");
    repeat (2) begin @(posedge clk); #1; end
    resetn = 1'b1;
    chk("abandoned_cmd_q", 64'(cmd_q.size()), 64'd0);
    @(posedge clk); #1;
    // New request accepted afterwards.
    plan(1'b1, 1'b1, 2'b10, 32'h0, 0, 3'b001, 32'h0BADF00D, 1'b0, 1'b0);
    issue(1'b1, 1'b1, 2'b10, 32'h0, 0);
    wait_done();
    chk("responses_seen", 64'(n_rsp), 64'd47);

    finish_sim();
  end
endmodule
